rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter that shares one downstream resource, such as the 4-to-2 encoded datapath, between four clients. Each request is a line of a 4-bit vector. Each grant is one-hot with an encoded 2-bit owner index, so the winner index plays the role of the encoder output `y`. Grants are held until the owner signals completion, drops its request, or exceeds a hold limit. Fairness comes from a rotating priority pointer. After reset, priority is 0 > 1 > 2 > 3, which matches the fixed priority order of the encoder.

---
 rtl/rr_arbiter4_if.sv | 19 +
 rtl/rr_arbiter4.sv | 118 +++++++++++
 tb/tb_rr_arbiter4.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter4_if.sv
// Arbiter request/grant bundle: clients drive req/done, the arbiter drives the grant side.
interface rr_arbiter4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    modport master (
        output req, done,
        input  gnt, gnt_id, busy, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, busy, timeout
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-client round-robin arbiter; one-cycle grant latency, one idle cycle between owners.
// Grant held until done, request drop, or MAX_HOLD cycles (forced release pulses timeout).
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter4_if.slave  arb
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [7:0] r_hold_cnt;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_id;
    logic       r_busy;
    logic       r_timeout;

    state_t     w_state_nxt;
    logic [1:0] w_ptr_nxt;
    logic [7:0] w_hold_nxt;
    logic [3:0] w_gnt_nxt;
    logic [1:0] w_gnt_id_nxt;
    logic       w_busy_nxt;
    logic       w_timeout_nxt;
    logic [1:0] w_sel;

    // Rotate requests so the pointer position becomes bit 0, then take the lowest set bit.
    function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [7:0] dbl;
        logic [3:0] rot;
        logic [1:0] pos;
        dbl = {req, req};
        rot = dbl[ptr +: 4];
        if (rot[0])      pos = 2'd0;
        else if (rot[1]) pos = 2'd1;
        else if (rot[2]) pos = 2'd2;
        else             pos = 2'd3;
        return ptr + pos;
    endfunction

    assign w_sel = pick(arb.req, r_ptr);

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                w_gnt_nxt    = 4'b0000;
                w_gnt_id_nxt = 2'd0;
                w_busy_nxt   = 1'b0;
                if (|arb.req) begin
                    w_gnt_nxt    = 4'b0001 << w_sel;
                    w_gnt_id_nxt = w_sel;
                    w_busy_nxt   = 1'b1;
                    w_hold_nxt   = 8'd0;
                    w_state_nxt  = GRANT;
                end
            end
            GRANT: begin
                if (arb.done || !arb.req[r_gnt_id] || (r_hold_cnt == HOLD_LAST)) begin
                    // done and owner-drop take precedence, so timeout only flags a pure hold-limit release
                    w_timeout_nxt = !arb.done && arb.req[r_gnt_id];
                    w_gnt_nxt     = 4'b0000;
                    w_gnt_id_nxt  = 2'd0;
                    w_busy_nxt    = 1'b0;
                    w_ptr_nxt     = r_gnt_id + 2'd1;
                    w_state_nxt   = IDLE;
                end else begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_gnt_nxt    = 4'b0000;
                w_gnt_id_nxt = 2'd0;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= 2'd0;
            r_hold_cnt <= 8'd0;
            r_gnt      <= 4'b0000;
            r_gnt_id   <= 2'd0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_busy     <= w_busy_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign arb.gnt     = r_gnt;
    assign arb.gnt_id  = r_gnt_id;
    assign arb.busy    = r_busy;
    assign arb.timeout = r_timeout;
endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed vectors with literal checks plus a per-cycle reference model.
module tb_rr_arbiter4;
    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    rr_arbiter4_if arb_if ();

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb_if.slave)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the resource, for how many cycles it has been visible, next priority.
    int   m_owner = -1;
    int   m_held  = 0;
    int   m_ptr   = 0;
    logic m_to    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_owner < 0 && arb_if.req[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                        m_held  = 1;
                    end
                end
            end else if (arb_if.done || !arb_if.req[m_owner]) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else if (m_held == MAX_HOLD) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held = m_held + 1;
            end
        end
    end

    function automatic logic [7:0] model_out();
        logic [3:0] g;
        logic [1:0] id;
        g  = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        id = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        return {g, id, (m_owner >= 0), m_to};
    endfunction

    function automatic logic [7:0] dut_out();
        return {arb_if.gnt, arb_if.gnt_id, arb_if.busy, arb_if.timeout};
    endfunction

    always @(posedge clk) begin
        #2;
        n_chk++;
        if (dut_out() !== model_out()) begin
            n_err++;
            $display("FAIL model t=%0t {gnt,id,busy,to}: got %b want %b", $time, dut_out(), model_out());
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    logic [3:0] rot_exp [5];

    initial begin
        rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        arb_if.req  = 4'b0000;
        arb_if.done = 1'b0;

        // Reset visible without any clock edge
        #1 rst = 1'b1;
        arb_if.req = 4'b1111;
        #1 chk("reset_outputs", dut_out(), 8'b0000_00_0_0);
        cyc(); cyc();
        rst = 1'b0;
        arb_if.req = 4'b0000;

        // Single request, done pulse, regrant
        cyc();
        arb_if.req = 4'b0001;
        cyc(); chk("single_grant", dut_out(), 8'b0001_00_1_0);
        arb_if.done = 1'b1;
        cyc(); chk("single_release", dut_out(), 8'b0000_00_0_0);
        arb_if.done = 1'b0;
        cyc(); chk("single_regrant", dut_out(), 8'b0001_00_1_0);
        arb_if.req = 4'b0000;
        cyc();
        pulse_reset();

        // Rotation with all four requesting
        arb_if.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cyc(); chk($sformatf("rot_grant%0d", i), {4'b0000, arb_if.gnt}, {4'b0000, rot_exp[i]});
            cyc(); chk($sformatf("rot_hold%0d", i), {4'b0000, arb_if.gnt}, {4'b0000, rot_exp[i]});
            arb_if.done = 1'b1;
            cyc(); chk($sformatf("rot_gap%0d", i), dut_out(), 8'b0000_00_0_0);
            arb_if.done = 1'b0;
        end
        arb_if.req = 4'b0000;
        cyc();

        // Hold-limit release and wrap of the pointer from 3 back to requester 2
        arb_if.req = 4'b0100;
        for (int i = 1; i <= MAX_HOLD; i++) begin
            cyc(); chk($sformatf("to_hold%0d", i), dut_out(), 8'b0100_10_1_0);
        end
        cyc(); chk("to_release", dut_out(), 8'b0000_00_0_1);
        cyc(); chk("to_regrant", dut_out(), 8'b0100_10_1_0);
        arb_if.req = 4'b0000;
        cyc(); cyc();

        // Owner withdrawal while another client is waiting
        arb_if.req = 4'b0010;
        cyc(); chk("wd_grant1", dut_out(), 8'b0010_01_1_0);
        arb_if.req = 4'b0011;
        cyc(); chk("wd_keep1", dut_out(), 8'b0010_01_1_0);
        arb_if.req = 4'b0001;
        cyc(); chk("wd_release", dut_out(), 8'b0000_00_0_0);
        cyc(); chk("wd_grant0", dut_out(), 8'b0001_00_1_0);
        arb_if.req = 4'b0000;
        cyc(); cyc();

        // Asynchronous reset in the middle of a grant to client 3
        arb_if.req = 4'b1000;
        cyc(); chk("mid_grant3", dut_out(), 8'b1000_11_1_0);
        arb_if.req = 4'b1010;
        #2 rst = 1'b1;
        #1 chk("mid_reset", dut_out(), 8'b0000_00_0_0);
        #1 rst = 1'b0;
        cyc(); chk("mid_after", dut_out(), 8'b0010_01_1_0);
        arb_if.req = 4'b0000;
        cyc();

        // Sustained contention: successive forced releases rotate through every client
        arb_if.req = 4'b1111;
        repeat (45) cyc();
        arb_if.req = 4'b0000;
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
